// File: rtl/f1_start_ctrl_pkg.sv
// Shared types and constants for the F1 start-light sequencer.
// Holds the controller state encoding and the LFSR seed/tap definitions.
package f1_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LIGHTS,
        HOLD,
        GO,
        DONE,
        FAULT
    } state_t;

    localparam logic [6:0] LFSR_SEED = 7'h01;
    // Taps x^7 + x^6 + 1 map onto register bits 6 and 5
    localparam logic [6:0] LFSR_TAPS = 7'h60;

    function automatic logic [6:0] lfsr_next(input logic [6:0] q);
        return {q[5:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/f1_start_ctrl_lfsr7.sv
// Free-running 7-bit maximal-length LFSR used to randomise the hold time.
// The all-zero lock-up state is unreachable from the non-zero seed.
module lfsr7
    import f1_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [6:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= LFSR_SEED;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/f1_start_ctrl.sv
// Start-light sequencer: steps the lights on divider ticks, holds for a
// pseudo-random number of ticks, then times the driver's reaction.
module f1_start_ctrl #(
    parameter int D_WIDTH  = 8,
    parameter int N_WIDTH  = 16,
    parameter int LIGHT_N  = 24,
    parameter int RT_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                trigger,
    input  logic                react,
    input  logic                tick,
    output logic                tick_en,
    output logic [N_WIDTH-1:0]  tick_n,
    output logic [D_WIDTH-1:0]  lights,
    output logic [RT_WIDTH-1:0] rt_count,
    output logic                rt_valid,
    output logic                false_start,
    output logic                busy
);

    import f1_pkg::*;

    localparam logic [D_WIDTH-1:0]  LIGHTS_ALL = '1;
    localparam logic [RT_WIDTH-1:0] RT_MAX     = '1;
    localparam logic [N_WIDTH-1:0]  TICK_DIV   = N_WIDTH'(LIGHT_N);

    state_t                state;
    state_t                state_nx;
    logic [D_WIDTH-1:0]    lights_nx;
    logic [RT_WIDTH-1:0]   rt_count_nx;
    logic                  tick_en_nx;
    logic                  rt_valid_nx;
    logic                  false_start_nx;
    logic                  busy_nx;
    logic [6:0]            hold_cnt;
    logic [6:0]            hold_nx;
    logic [6:0]            lfsr_q;
    logic                  tick_q;

    lfsr7 u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    function automatic logic [RT_WIDTH-1:0] sat_inc(input logic [RT_WIDTH-1:0] v);
        return (v == RT_MAX) ? v : v + 1'b1;
    endfunction

    // The divider may keep pulsing while disabled; only enabled ticks count
    assign tick_q = tick & tick_en;

    always_comb begin
        state_nx       = state;
        lights_nx      = lights;
        rt_count_nx    = rt_count;
        tick_en_nx     = tick_en;
        rt_valid_nx    = rt_valid;
        false_start_nx = false_start;
        hold_nx        = hold_cnt;

        case (state)
            IDLE, DONE, FAULT: begin
                if (trigger) begin
                    state_nx       = LIGHTS;
                    lights_nx      = '0;
                    rt_count_nx    = '0;
                    rt_valid_nx    = 1'b0;
                    false_start_nx = 1'b0;
                    tick_en_nx     = 1'b1;
                end
            end
            LIGHTS, HOLD: begin
                // A press before lights-out beats any same-cycle tick
                if (react) begin
                    state_nx       = FAULT;
                    false_start_nx = 1'b1;
                    tick_en_nx     = 1'b0;
                    rt_valid_nx    = 1'b0;
                end else if (tick_q) begin
                    if (state == LIGHTS) begin
                        if (lights == LIGHTS_ALL) begin
                            state_nx = HOLD;
                            hold_nx  = lfsr_q;
                        end else begin
                            lights_nx = {lights[D_WIDTH-2:0], 1'b1};
                        end
                    end else if (hold_cnt <= 7'd1) begin
                        state_nx    = GO;
                        lights_nx   = '0;
                        tick_en_nx  = 1'b0;
                        rt_count_nx = '0;
                    end else begin
                        hold_nx = hold_cnt - 7'd1;
                    end
                end
            end
            GO: begin
                if (react) begin
                    state_nx    = DONE;
                    rt_valid_nx = 1'b1;
                end else begin
                    rt_count_nx = sat_inc(rt_count);
                    if (rt_count_nx == RT_MAX) begin
                        state_nx    = DONE;
                        rt_valid_nx = 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        busy_nx = (state_nx == LIGHTS) || (state_nx == HOLD) || (state_nx == GO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lights      <= '0;
            tick_en     <= 1'b0;
            tick_n      <= TICK_DIV;
            rt_count    <= '0;
            rt_valid    <= 1'b0;
            false_start <= 1'b0;
            busy        <= 1'b0;
            hold_cnt    <= '0;
        end else begin
            state       <= state_nx;
            lights      <= lights_nx;
            tick_en     <= tick_en_nx;
            tick_n      <= TICK_DIV;
            rt_count    <= rt_count_nx;
            rt_valid    <= rt_valid_nx;
            false_start <= false_start_nx;
            busy        <= busy_nx;
            hold_cnt    <= hold_nx;
        end
    end

endmodule

// File: doc/f1_start_ctrl.md
Name: f1_start_ctrl

Overview:
- Sequencing controller for the F1 start-light datapath.
- Owns the external clock-divider (tick generator): drives its enable and divide value, consumes its tick, and produces the light pattern.
- Adds a pseudo-random hold before lights-out, then measures driver reaction time in clk cycles and flags false starts.
- Sits at top level between the clock divider and the light outputs.

Parameters:
- D_WIDTH, 8, light vector width; the full-on pattern is all ones.
- N_WIDTH, 16, width of the divide value driven to the tick generator.
- LIGHT_N, 24, divide value used during the LIGHTS and HOLD states (tick period = LIGHT_N+1 cycles).
- RT_WIDTH, 16, width of the reaction-time counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- trigger  in  1  start request, level-sampled each cycle
- react  in  1  driver button, already synchronised and debounced
- tick  in  1  one-cycle pulse from the tick generator
- tick_en  out  1  enable to the tick generator
- tick_n  out  N_WIDTH  divide value to the tick generator
- lights  out  D_WIDTH  light pattern
- rt_count  out  RT_WIDTH  measured reaction time
- rt_valid  out  1  rt_count holds a valid result
- false_start  out  1  react seen before lights-out
- busy  out  1  high in LIGHTS, HOLD, GO

Behaviour:
- All outputs are registered.
- Reset (synchronous, dominates everything, including mid-sequence):
  - state=IDLE
  - lights=0, tick_en=0, tick_n=LIGHT_N
  - rt_count=0, rt_valid=0, false_start=0, busy=0
  - hold counter=0, LFSR=7'h01
- LFSR:
  - 7-bit Fibonacci, taps x^7+x^6+1: next = {q[5:0], q[6]^q[5]}.
  - Advances every clk cycle in every state except reset.
  - Never reaches zero; period 127.
- tick is ignored whenever tick_en=0. tick_n stays LIGHT_N at all times.
- IDLE:
  - trigger=1 -> LIGHTS next cycle.
  - On entry: lights=0, rt_valid=0, false_start=0, rt_count=0, tick_en=1.
- LIGHTS:
  - Each tick: lights <= {lights[D_WIDTH-2:0], 1'b1}. Sequence is 0x01, 0x03, ... 0xFF.
  - A tick arriving while lights is all ones -> HOLD. The hold counter loads the LFSR value from that cycle (1..127).
- HOLD:
  - lights stays all ones.
  - Each tick decrements the hold counter.
  - A tick with counter==1 -> GO. On that edge: lights=0, tick_en=0, rt_count=0.
- GO:
  - Let the first GO cycle be k=0.
  - Each GO cycle with react=0: rt_count increments, saturating at 2^RT_WIDTH-1.
  - react=1 in GO cycle k -> DONE with rt_count=k and rt_valid=1.
  - Saturation reached -> DONE with rt_count=all ones and rt_valid=1.
- False start:
  - react=1 in any LIGHTS or HOLD cycle -> FAULT. This applies even if a tick arrives in the same cycle; react wins.
  - FAULT: false_start=1, tick_en=0, lights frozen at their current value, rt_valid=0.
- DONE and FAULT:
  - Outputs held.
  - trigger=1 -> LIGHTS, with the same entry actions as from IDLE.
- trigger while busy=1 is ignored.
- react in IDLE, DONE or FAULT is ignored.

Decomposition:
- Package f1_pkg:
  - state enum {IDLE, LIGHTS, HOLD, GO, DONE, FAULT}
  - LFSR seed constant 7'h01
  - LFSR tap constant
- Sub-module lfsr7: clk, rst, q[6:0]; free-running, seed 7'h01 on reset.

Test Plan:
- Reset then idle: rst held 2 cycles, then 20 idle cycles -> lights=0, tick_en=0, tick_n=24, busy=0, rt_valid=0, false_start=0.
- Normal run, tick driven every 25 cycles:
  - trigger pulse -> lights steps 0x01 through 0xFF on successive ticks.
  - Hold length in ticks equals the LFSR value captured at the 0xFF->HOLD tick (checked against a bench LFSR model, range 1..127).
  - Then lights=0 and tick_en=0.
- Reaction measurement: react asserted in GO cycle 37 -> rt_count=37, rt_valid=1, busy=0; outputs held for 50 further cycles.
- False start cases:
  - react pulse while lights=0x07 -> false_start=1, lights frozen at 0x07, tick_en=0.
  - A second run with react and tick in the same HOLD cycle -> FAULT, not GO.
- Saturation and restart:
  - RT_WIDTH=4 and no react -> DONE after rt_count reaches 15.
  - trigger in DONE -> rt_valid=0, lights=0, then 0x01 on the next tick.
- Mid-operation reset and busy trigger:
  - rst during HOLD -> all outputs at reset values on the following cycle.
  - trigger pulses during LIGHTS -> sequence unaffected.
